// File: rtl/shiftreg_serializer_ctrl_if.sv
// ---------------------------------------------------------------------------
// shiftreg_serializer_ctrl_if
//
// Bundles every non-clock signal of the serializer controller.
//
// Handshake semantics (word input):
//   A word transfers on a rising Clock edge where InValid and InReady are both
//   high. Once InValid is raised, the producer holds it and InData stable until
//   that transfer. InReady depends only on controller state, never on InValid.
//   The serial side has no ready: SerStall=1 keeps the current bit on SerOut
//   with SerValid low. A bit is consumed on every cycle with SerValid=1.
//
// Modports:
//   slave  - the controller's view (consumes words, drives the shift register
//            pins and the serial output)
//   master - the environment's view (producer, shift register, consumer)
//
// Signals:
//   InData/InValid/InReady        parallel word handshake
//   SrData/SrLoad/SrEnable/
//   SrShiftIn/SrShiftOut          LPM right-shift register pins
//   SerOut/SerValid/SerLast/
//   SerStall                      serial bit stream and back-pressure
//   Busy                          a word is in flight
// ---------------------------------------------------------------------------
interface shiftreg_serializer_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] InData;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] SrData;
  logic             SrLoad;
  logic             SrEnable;
  logic             SrShiftIn;
  logic             SrShiftOut;
  logic             SerOut;
  logic             SerValid;
  logic             SerLast;
  logic             SerStall;
  logic             Busy;

  modport slave (
    input  InData, InValid, SrShiftOut, SerStall,
    output InReady, SrData, SrLoad, SrEnable, SrShiftIn,
           SerOut, SerValid, SerLast, Busy
  );

  modport master (
    output InData, InValid, SrShiftOut, SerStall,
    input  InReady, SrData, SrLoad, SrEnable, SrShiftIn,
           SerOut, SerValid, SerLast, Busy
  );
endinterface

// File: rtl/shiftreg_serializer_ctrl.sv
// ---------------------------------------------------------------------------
// shiftreg_serializer_ctrl
//
// Drives an LPM right-shifting register as a word-to-bit serializer. A word
// accepted over the valid/ready handshake is captured into SrData, loaded into
// the register in a one-cycle LOAD state, then shifted out LSB-first: the
// register's LSB (SrShiftOut) is presented on SerOut, and each non-stalled
// cycle consumes one bit and pulses SrEnable to shift the next bit in place.
//
// Optional feature (macro SHIFTCTRL_PARITY_EN): after the last data bit one
// extra beat carries the even parity (XOR) of the word, and SerLast moves to
// that beat. Without the macro there is no PAR state and no accumulator.
//
// Ports:
//   Clock      rising-edge clock
//   Sclr       synchronous active-high reset
//   bus        shiftreg_serializer_ctrl_if.slave (handshake, register pins,
//              serial output, Busy)
//   dbg_state  current FSM state encoding (0 IDLE, 1 LOAD, 2 SHIFT, 3 PAR)
// ---------------------------------------------------------------------------
module shiftreg_serializer_ctrl #(
  parameter int   WIDTH = 16,
  parameter logic FILL  = 1'b0
) (
  input  logic                          Clock,
  input  logic                          Sclr,
  shiftreg_serializer_ctrl_if.slave     bus,
  output logic [1:0]                    dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
`ifdef SHIFTCTRL_PARITY_EN
    , ST_PAR = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_data_q, sr_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SHIFTCTRL_PARITY_EN
  logic             par_q, par_d;
`endif

  logic in_ready;
  logic sr_load;
  logic sr_enable;
  logic ser_out;
  logic ser_valid;
  logic ser_last;

  always_comb begin
    state_d   = state_q;
    sr_data_d = sr_data_q;
    cnt_d     = cnt_q;
`ifdef SHIFTCTRL_PARITY_EN
    par_d     = par_q;
`endif
    in_ready  = 1'b0;
    sr_load   = 1'b0;
    sr_enable = 1'b0;
    ser_out   = bus.SrShiftOut;
    ser_valid = 1'b0;
    ser_last  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.InValid) begin
          sr_data_d = bus.InData;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Load needs Enable as well on the LPM register.
        sr_load   = 1'b1;
        sr_enable = 1'b1;
        cnt_d     = '0;
`ifdef SHIFTCTRL_PARITY_EN
        par_d     = 1'b0;
`endif
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
`ifndef SHIFTCTRL_PARITY_EN
        // Not gated by the stall so SerLast stays up while the bit is held.
        ser_last = (cnt_q == LAST_IDX);
`endif
        if (!bus.SerStall) begin
          ser_valid = 1'b1;
          sr_enable = 1'b1;
          cnt_d     = cnt_q + CW'(1);
`ifdef SHIFTCTRL_PARITY_EN
          par_d     = par_q ^ bus.SrShiftOut;
`endif
          if (cnt_q == LAST_IDX) begin
`ifdef SHIFTCTRL_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end

`ifdef SHIFTCTRL_PARITY_EN
      ST_PAR: begin
        // Register is not shifted here; the beat comes from the accumulator.
        ser_out  = par_q;
        ser_last = 1'b1;
        if (!bus.SerStall) begin
          ser_valid = 1'b1;
          state_d   = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Sclr) begin
      state_q   <= ST_IDLE;
      sr_data_q <= '0;
      cnt_q     <= '0;
`ifdef SHIFTCTRL_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_data_q <= sr_data_d;
      cnt_q     <= cnt_d;
`ifdef SHIFTCTRL_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.InReady   = in_ready;
  assign bus.SrData    = sr_data_q;
  assign bus.SrLoad    = sr_load;
  assign bus.SrEnable  = sr_enable;
  assign bus.SrShiftIn = FILL;
  assign bus.SerOut    = ser_out;
  assign bus.SerValid  = ser_valid;
  assign bus.SerLast   = ser_last;
  assign bus.Busy      = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_shiftreg_serializer_ctrl.sv
module tb_shiftreg_serializer_ctrl;
  localparam int W = 16;
`ifdef SHIFTCTRL_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sclr;
  always #5 clk = ~clk;

  shiftreg_serializer_ctrl_if #(.WIDTH(W)) bus ();
  logic [1:0] dbg_state;

  shiftreg_serializer_ctrl #(.WIDTH(W), .FILL(1'b0)) dut (
    .Clock     (clk),
    .Sclr      (sclr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Behavioural LPM right-shift register (environment, not a reference).
  logic [W-1:0] sr_reg;
  always @(posedge clk) begin
    if (bus.SrEnable)
      sr_reg <= bus.SrLoad ? bus.SrData : {bus.SrShiftIn, sr_reg[W-1:1]};
  end
  assign bus.SrShiftOut = sr_reg[0];

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  // Each entry is {bit, last}. A word accepted on a handshake expands into its
  // bits LSB-first, plus the parity beat when that feature is built in.
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];

  always @(negedge clk) begin
    if (bus.SerValid) begin
      obs_q.push_back({bus.SerOut, bus.SerLast});
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_beat: got beat %b with nothing expected at %0t",
                 {bus.SerOut, bus.SerLast}, $time);
      end else begin
        check("sb_beat", {30'd0, bus.SerOut, bus.SerLast}, {30'd0, exp_q.pop_front()});
      end
    end
    check("valid_during_stall", bus.SerValid & bus.SerStall, 0);
    if (sclr) begin
      exp_q.delete();
    end else if (bus.InValid && bus.InReady) begin
      for (int k = 0; k < W; k++)
        exp_q.push_back({bus.InData[k], (k == W-1) && (PX == 0)});
      if (PX != 0)
        exp_q.push_back({^bus.InData, 1'b1});
    end
  end

  // ---------------- driver tasks ----------------
  // Sends one word; stalls beat b (1-based) for slen cycles when mask[b] is set.
  task automatic send_word(input logic [W-1:0] w, input logic [31:0] mask, input int slen,
                           output int gap, output int last_cycles);
    int g, beats, scnt;
    obs_q.delete();
    bus.InData  = w;
    bus.InValid = 1'b1;
    g = 0;
    while (!bus.InReady && g < 100) begin
      tick();
      g++;
    end
    check("in_ready_wait", bus.InReady, 1);
    tick();
    bus.InValid = 1'b0;
    g = 1; beats = 0; scnt = 0; last_cycles = 0;
    while (!bus.InReady && g < 200) begin
      bus.SerStall = 1'b0;
      if (g >= 2 && mask[beats+1] && scnt < slen) begin
        bus.SerStall = 1'b1;
        scnt++;
      end
      #3;
      check("sr_load_pulse", bus.SrLoad, (g == 1));
      if (bus.SerStall) begin
        check("stall_sr_enable", bus.SrEnable, 0);
        check("stall_ser_valid", bus.SerValid, 0);
      end
      if (bus.SerLast) last_cycles++;
      if (bus.SerValid) begin
        beats++;
        scnt = 0;
      end
      tick();
      g++;
    end
    bus.SerStall = 1'b0;
    gap = g;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (bus.Busy && g < 300) begin
      tick();
      g++;
    end
    check("idle_reached", bus.Busy, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] word;
    logic [31:0]  stall_mask;
    int           stall_len;
    int           exp_gap;
    int           exp_ones;
    int           exp_last_cycles;
    logic         exp_final_bit;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int gap, lc, ones, nlast, t0, t1, c, beats;
    logic hs;
    int a5_bits[16];

    vecs[0] = '{16'hA5C3, 32'h0, 0, 18 + PX, 8, 1, (PX != 0) ? 1'b0 : 1'b1};
    vecs[1] = '{16'h0001, (32'h1 << 1) | (32'h1 << 8) | (32'h1 << 16), 3, 27 + PX, 1,
                (PX != 0) ? 1 : 4, (PX != 0) ? 1'b1 : 1'b0};
    vecs[2] = '{16'hFFFF, 32'h0, 0, 18 + PX, 16, 1, (PX != 0) ? 1'b0 : 1'b1};
    vecs[3] = '{16'h8001, 32'h1 << 16, 2, 20 + PX, 2, (PX != 0) ? 1 : 3, (PX != 0) ? 1'b0 : 1'b1};
    vecs[4] = '{16'h0007, 32'h1 << 17, 2, (PX != 0) ? 21 : 18, 3, (PX != 0) ? 3 : 1,
                (PX != 0) ? 1'b1 : 1'b0};
    vecs[5] = '{16'h0003, 32'h0, 0, 18 + PX, 2, 1, 1'b0};
    a5_bits = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

    // Reset
    sclr = 1'b1;
    bus.InValid = 1'b0;
    bus.InData = '0;
    bus.SerStall = 1'b0;
    tick();
    tick();
    sclr = 1'b0;
    #3;
    check("rst_in_ready", bus.InReady, 1);
    check("rst_busy", bus.Busy, 0);
    check("rst_ser_valid", bus.SerValid, 0);
    check("rst_ser_last", bus.SerLast, 0);
    check("rst_sr_load", bus.SrLoad, 0);
    check("rst_sr_enable", bus.SrEnable, 0);
    check("rst_sr_data", bus.SrData, 0);
    check("rst_state", dbg_state, 0);
    check("shift_in_fill", bus.SrShiftIn, 0);

    // Idle with no traffic; stall toggling must not matter here
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.SerStall = i[0];
      #3;
      check("idle_in_ready", bus.InReady, 1);
      check("idle_busy", bus.Busy, 0);
      check("idle_ser_valid", bus.SerValid, 0);
      check("idle_sr_load", bus.SrLoad, 0);
    end
    tick();
    bus.SerStall = 1'b0;

    // Table-driven words
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].word, vecs[v].stall_mask, vecs[v].stall_len, gap, lc);
      check("vec_ready_gap", gap, vecs[v].exp_gap);
      check("vec_last_cycles", lc, vecs[v].exp_last_cycles);
      check("vec_beats", obs_q.size(), W + PX);
      ones = 0;
      nlast = 0;
      for (int k = 0; k < obs_q.size(); k++) begin
        if (k < W) ones += int'(obs_q[k][1]);
        nlast += int'(obs_q[k][0]);
      end
      check("vec_ones", ones, vecs[v].exp_ones);
      check("vec_last_count", nlast, 1);
      if (obs_q.size() > 0) begin
        check("vec_final_last", obs_q[obs_q.size()-1][0], 1);
        check("vec_final_bit", obs_q[obs_q.size()-1][1], vecs[v].exp_final_bit);
      end
    end

    // Explicit bit order of 0xA5C3
    send_word(16'hA5C3, 32'h0, 0, gap, lc);
    check("a5c3_gap", gap, 18 + PX);
    for (int k = 0; k < 16; k++)
      check("a5c3_bit", obs_q[k][1], a5_bits[k]);

    // Back-to-back words with InValid held
    obs_q.delete();
    bus.InData = 16'hFFFF;
    bus.InValid = 1'b1;
    t0 = -1; t1 = -1; c = 0;
    while (c < 100 && t1 < 0) begin
      #3;
      hs = bus.InValid & bus.InReady;
      tick();
      c++;
      if (hs) begin
        if (t0 < 0) begin
          t0 = c;
          bus.InData = 16'h0000;
        end else begin
          t1 = c;
          bus.InValid = 1'b0;
        end
      end
    end
    bus.InValid = 1'b0;
    check("b2b_accept_gap", t1 - t0, W + 2 + PX);
    wait_idle();
    tick();
    check("b2b_beats", obs_q.size(), 2 * (W + PX));

    // Sclr on beat 7 of 0x1234
    obs_q.delete();
    bus.InData = 16'h1234;
    bus.InValid = 1'b1;
    tick();
    bus.InValid = 1'b0;
    beats = 0; c = 0;
    while (beats < 6 && c < 100) begin
      #3;
      if (bus.SerValid) beats++;
      tick();
      c++;
    end
    sclr = 1'b1;
    #3;
    check("sclr_beat7_valid", bus.SerValid, 1);
    tick();
    sclr = 1'b0;
    #3;
    check("sclr_ser_valid", bus.SerValid, 0);
    check("sclr_in_ready", bus.InReady, 1);
    check("sclr_busy", bus.Busy, 0);
    check("sclr_state", dbg_state, 0);
    check("sclr_beats", obs_q.size(), 7);
    tick();
    #3;
    check("sclr_quiet", bus.SerValid, 0);
    tick();
    send_word(16'h8001, 32'h0, 0, gap, lc);
    check("post_sclr_gap", gap, 18 + PX);
    check("post_sclr_beats", obs_q.size(), W + PX);
    check("post_sclr_first", obs_q[0][1], 1);
    check("post_sclr_msb", obs_q[W-1][1], 1);

    // Randomized traffic with stalls and occasional resets
    for (int i = 0; i < 1500; i++) begin
      if (!bus.InValid && $urandom_range(0, 2) == 0) begin
        bus.InValid = 1'b1;
        bus.InData = W'($urandom);
      end
      bus.SerStall = ($urandom_range(0, 3) == 0);
      sclr = ($urandom_range(0, 299) == 0);
      #3;
      hs = bus.InValid & bus.InReady & ~sclr;
      tick();
      if (hs) bus.InValid = 1'b0;
    end
    sclr = 1'b0;
    bus.InValid = 1'b0;
    bus.SerStall = 1'b0;
    wait_idle();
    tick();
    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/shiftreg_serializer_ctrl.md
# shiftreg_serializer_ctrl

Sequencing controller that turns an LPM-style right-shifting register (`lpm_direction = "RIGHT"`, width `WIDTH`) into a word-to-bit serializer.
- Accepts parallel words over a valid/ready handshake and drives the register's `Data`/`Load`/`Enable`/`ShiftIn` pins.
- Observes `ShiftOut` and presents the serial bitstream LSB-first with valid/last/stall qualifiers.
- Sits between the EBR shift-register instance and any bit-serial consumer, e.g. a UART-style transmitter or a test-pattern output.

## Interface
Parameters:
- `WIDTH`, 16, shift register width in bits; must be ≥ 2.
- `FILL`, 1'b0, constant driven on `SrShiftIn` (bit entering the MSB on each shift).

Ports:
- `Clock` in 1: single clock; all logic rises on its rising edge.
- `Sclr` in 1: reset, synchronous and active-high.
- `InData` in WIDTH: parallel word to serialize.
- `InValid` in 1: `InData` valid.
- `InReady` out 1: controller accepts a word this cycle.
- `SrData` out WIDTH: to shift register `Data`.
- `SrLoad` out 1: to shift register `Load`.
- `SrEnable` out 1: to shift register `Enable`.
- `SrShiftIn` out 1: to shift register `ShiftIn`.
- `SrShiftOut` in 1: from shift register `ShiftOut` (the register's current LSB).
- `SerOut` out 1: serial data bit.
- `SerValid` out 1: `SerOut` valid this cycle.
- `SerLast` out 1: final bit of the current word/frame.
- `SerStall` in 1: consumer back-pressure; freezes shifting.
- `Busy` out 1: word in flight (state ≠ IDLE).

## Operation
- States: IDLE, LOAD, SHIFT, PAR. PAR exists only with the configuration macro.
- IDLE:
  - `InReady` = 1.
  - On `InValid & InReady`: capture `InData` into `SrData` (a register that holds its value until the next accept), then go to LOAD.
- LOAD, one cycle:
  - `SrLoad` = 1 and `SrEnable` = 1, so the register loads `SrData` at the edge.
  - Clear the bit counter and parity accumulator, then go to SHIFT.
- SHIFT:
  - `SerOut` = `SrShiftOut`.
  - When `SerStall` = 0: `SerValid` = 1, `SrEnable` = 1, counter +1, and the parity accumulator XORs in `SrShiftOut`.
  - When `SerStall` = 1: `SerValid` = 0, `SrEnable` = 0, and counter and accumulator hold.
  - Counter width is `$clog2(WIDTH)`; bit index runs 0..WIDTH-1.
  - On the accepted bit at index WIDTH-1: go to IDLE (or to PAR when the macro is set). `SerLast` = 1 on that bit only when the macro is unset.
- PAR: see Configuration.
- `SrLoad` = 0 in every state except LOAD.
- `SrShiftIn` = `FILL` at all times.
- Bits are emitted LSB-first: bit k of the accepted word appears on the k-th accepted `SerOut` beat.

## Timing
- Reset values after an `Sclr` edge:
  - state = IDLE; `InReady` = 1, `Busy` = 0.
  - `SerValid`, `SerLast`, `SrLoad`, `SrEnable` = 0.
  - `SrData` = 0, counter = 0, parity = 0.
- `Sclr` mid-word: the word is abandoned with no further `SerValid`. Stale contents of the shift register are ignored.
- `Sclr` has priority over a simultaneous handshake; the word is not accepted.
- Latency and throughput:
  - Accept edge at cycle t; LOAD in cycle t+1; first `SerValid` in cycle t+2; last bit in cycle t+WIDTH+1 with no stalls.
  - Next accept is possible in cycle t+WIDTH+2. Throughput is one word per WIDTH+2 cycles (WIDTH+3 with parity).
- `InReady` is combinational from state only and never depends on `InValid`.
- A stall on the last bit holds `SerLast` and `SerOut` stable until the bit is accepted.
- `SerStall` is ignored in IDLE and LOAD.

## Configuration
- Macro `SHIFTCTRL_PARITY_EN`:
  - Defined: after bit WIDTH-1, enter PAR for one accepted beat.
    - `SerOut` = even parity (XOR of all WIDTH bits); `SerValid` = 1, `SerLast` = 1.
    - `SrEnable` = 0; `SerStall` is honoured exactly as in SHIFT.
    - Then return to IDLE.
  - Undefined: no PAR state and no accumulator logic; `SerLast` marks data bit WIDTH-1.

## Test plan
- Reset, then idle with `InValid` = 0 → `InReady` = 1, `Busy` = 0, `SerValid` = 0, `SrLoad` = 0 for 20 cycles.
- Send word 0xA5C3 with no stall → `SrLoad` pulses 1 cycle after accept. `SerOut` over 16 valid beats = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. `SerLast` is on beat 16. `InReady` returns 18 cycles after accept.
- Send 0x0001 with `SerStall` high on beats 1, 8 and 16 for 3 cycles each → `SrEnable` = 0 during the stalls and the bit sequence is unchanged. `SerLast` is held for 3 cycles and then accepted.
- Send back-to-back words 0xFFFF then 0x0000 with `InValid` held → second accept exactly WIDTH+2 cycles after the first; no bit lost or duplicated.
- Assert `Sclr` on beat 7 of 0x1234 → next cycle IDLE, `SerValid` = 0. A following word 0x8001 serializes correctly.
- With `SHIFTCTRL_PARITY_EN`:
  - 0x0007 → 17th beat `SerOut` = 1, `SerLast` = 1.
  - 0x0003 → 17th beat `SerOut` = 0.
